// File: rtl/mem_port_arbiter_pkg.sv
// ==== mem_port_arbiter_pkg : shared types and defaults for the memory port arbiter ====
// ==== rev 1.0 ====
`default_nettype none

package mem_port_arbiter_pkg;

  localparam int DEF_AW         = 32;
  localparam int DEF_DW         = 32;
  localparam int DEF_STARVE_MAX = 4;
  localparam int DEF_TIMEOUT    = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ==== mem_port_arbiter_if : requester, memory and pipeline-hold signals of the arbiter ====
// ==== rev 1.0 ====
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          I_REQ;
  logic [AW-1:0] I_ADDR;
  logic          I_GNT;
  logic          I_RVALID;
  logic [DW-1:0] I_RDATA;

  logic          D_REQ;
  logic          D_WE;
  logic [3:0]    D_BE;
  logic [AW-1:0] D_ADDR;
  logic [DW-1:0] D_WDATA;
  logic          D_GNT;
  logic          D_RVALID;
  logic [DW-1:0] D_RDATA;

  logic          M_REQ;
  logic          M_WE;
  logic [3:0]    M_BE;
  logic [AW-1:0] M_ADDR;
  logic [DW-1:0] M_WDATA;
  logic          M_READY;
  logic          M_RVALID;
  logic [DW-1:0] M_RDATA;

  logic          STALL_IF;
  logic          STALL_MEM;
  logic          ERR;

  // Arbiter side.
  modport slave (
    input  I_REQ, I_ADDR,
    output I_GNT, I_RVALID, I_RDATA,
    input  D_REQ, D_WE, D_BE, D_ADDR, D_WDATA,
    output D_GNT, D_RVALID, D_RDATA,
    output M_REQ, M_WE, M_BE, M_ADDR, M_WDATA,
    input  M_READY, M_RVALID, M_RDATA,
    output STALL_IF, STALL_MEM, ERR
  );

  // Pipeline requesters plus memory.
  modport master (
    output I_REQ, I_ADDR,
    input  I_GNT, I_RVALID, I_RDATA,
    output D_REQ, D_WE, D_BE, D_ADDR, D_WDATA,
    input  D_GNT, D_RVALID, D_RDATA,
    input  M_REQ, M_WE, M_BE, M_ADDR, M_WDATA,
    output M_READY, M_RVALID, M_RDATA,
    input  STALL_IF, STALL_MEM, ERR
  );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_arb_starve_sel.sv
// ==== arb_starve_sel : data-priority winner select with fetch anti-starvation counter ====
// ==== rev 1.0 ====
`default_nettype none

module arb_starve_sel
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  wire logic CLK,
  input  wire logic RST,
  input  wire logic fetch_req,
  input  wire logic data_req,
  input  wire logic gnt_en,
  output owner_t    winner,
  output logic      valid
);

  localparam int SW = cnt_width(STARVE_MAX);

  logic [SW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == SW'(STARVE_MAX));
  assign valid   = fetch_req | data_req;
  assign winner  = (data_req && !(fetch_req && starved)) ? OWN_D : OWN_I;

  // Only data grants taken over a waiting fetch count toward starvation.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      starve_cnt <= '0;
    end else if (gnt_en && valid) begin
      if (winner == OWN_I) begin
        starve_cnt <= '0;
      end else if (fetch_req && !starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ==== mem_port_arbiter : shares one memory port between IF fetch and MEM load/store ====
// ==== rev 1.0 ====
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input wire logic            CLK,
  input wire logic            RST,
  mem_port_arbiter_if.slave   bus
);

  localparam int TW = cnt_width(TIMEOUT);

  state_t        state;
  owner_t        owner;
  logic [TW-1:0] tmo_cnt;
  logic          err;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          m_req, m_we;
  logic [3:0]    m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  owner_t        sel_winner;
  logic          sel_valid;
  logic          in_idle;
  logic          busy;
  logic          tmo_hit;
  logic          done;
  logic [DW-1:0] resp_data;

  assign in_idle   = (state == ST_IDLE);
  assign busy      = (state == ST_ISSUE) || (state == ST_WAIT);
  assign tmo_hit   = busy && (tmo_cnt == TW'(TIMEOUT - 1));
  assign done      = tmo_hit || ((state == ST_WAIT) && bus.M_RVALID);
  assign resp_data = tmo_hit ? '0 : bus.M_RDATA;

  arb_starve_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_sel (
    .CLK       (CLK),
    .RST       (RST),
    .fetch_req (bus.I_REQ),
    .data_req  (bus.D_REQ),
    .gnt_en    (in_idle),
    .winner    (sel_winner),
    .valid     (sel_valid)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      owner    <= OWN_I;
      tmo_cnt  <= '0;
      err      <= 1'b0;
      i_gnt    <= 1'b0;
      i_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_gnt    <= 1'b0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_be     <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
    end else begin
      i_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sel_valid) begin
            owner   <= sel_winner;
            m_req   <= 1'b1;
            tmo_cnt <= '0;
            state   <= ST_ISSUE;
            if (sel_winner == OWN_D) begin
              d_gnt   <= 1'b1;
              m_we    <= bus.D_WE;
              m_be    <= bus.D_BE;
              m_addr  <= bus.D_ADDR;
              m_wdata <= bus.D_WDATA;
            end else begin
              i_gnt   <= 1'b1;
              m_we    <= 1'b0;
              m_be    <= 4'hF;
              m_addr  <= bus.I_ADDR;
              m_wdata <= '0;
            end
          end
        end
        ST_ISSUE, ST_WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // A watchdog abort completes the transaction with zero data.
          if (done) begin
            m_req <= 1'b0;
            state <= ST_IDLE;
            err   <= err | tmo_hit;
            if (owner == OWN_D) begin
              d_rvalid <= 1'b1;
              d_rdata  <= resp_data;
            end else begin
              i_rvalid <= 1'b1;
              i_rdata  <= resp_data;
            end
          end else if ((state == ST_ISSUE) && bus.M_READY) begin
            m_req <= 1'b0;
            state <= ST_WAIT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.I_GNT     = i_gnt;
  assign bus.I_RVALID  = i_rvalid;
  assign bus.I_RDATA   = i_rdata;
  assign bus.D_GNT     = d_gnt;
  assign bus.D_RVALID  = d_rvalid;
  assign bus.D_RDATA   = d_rdata;
  assign bus.M_REQ     = m_req;
  assign bus.M_WE      = m_we;
  assign bus.M_BE      = m_be;
  assign bus.M_ADDR    = m_addr;
  assign bus.M_WDATA   = m_wdata;
  assign bus.ERR       = err;
  assign bus.STALL_IF  = bus.I_REQ & ~i_rvalid;
  assign bus.STALL_MEM = bus.D_REQ & ~d_rvalid;

endmodule

`default_nettype wire
